// File: rtl/result_writer.sv
// result_writer: write-back end of the Sobel pipeline.
// Buffers the filtered pixel stream in a small skid FIFO and writes it, in
// raster order, to the output frame buffer through a single-port BRAM write
// port whose availability is signalled by gnt_i.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_run_i              start-of-frame pulse (also restarts a running frame)
//   wr_done_o             one-cycle pulse after the last write strobe
//   pixel_i, pixel_en_i   filtered pixel stream
//   gnt_i                 BRAM write port available this cycle
//   ena_o, wea_o          BRAM enable / write enable (one write per pop)
//   addr_o, d2mem_o       BRAM address / write data
//   ovf_o                 sticky: a pixel was dropped on a full FIFO
//   cnt_row_o, cnt_col_o  debug: row/column of the next pixel to write
module result_writer #(
  parameter int unsigned OUT_ROW    = 538,
  parameter int unsigned OUT_COL    = 538,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW = 19,
  localparam int unsigned DW = 8,
  localparam int unsigned CW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_run_i,
  output logic          wr_done_o,
  input  logic [DW-1:0] pixel_i,
  input  logic          pixel_en_i,
  input  logic          gnt_i,
  output logic          ena_o,
  output logic          wea_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] d2mem_o,
  output logic          ovf_o,
  output logic [CW-1:0] cnt_row_o,
  output logic [CW-1:0] cnt_col_o
);

  localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned NW    = PW + 1;
  localparam int unsigned TOTAL = OUT_ROW * OUT_COL;
  // One bit wider than the address so a frame filling the whole space still counts.
  localparam int unsigned PCW   = AW + 1;

  // Elaboration-time parameter sanity check.
  if ((BASE_ADDR + TOTAL) > (32'd1 << AW) || OUT_ROW == 0 || OUT_COL == 0 ||
      OUT_ROW >= (32'd1 << CW) || OUT_COL > (32'd1 << CW) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("result_writer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [NW-1:0]  count;
  logic [AW-1:0]  addr_q;
  logic [PCW-1:0] push_cnt;

  logic restart, push, pop, drop;
  logic full, empty, col_end, at_last, frame_open;

  assign full       = (count == NW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign col_end    = (cnt_col_o == CW'(OUT_COL - 1));
  assign at_last    = col_end && (cnt_row_o == CW'(OUT_ROW - 1));
  assign frame_open = (push_cnt != PCW'(TOTAL));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle FIFO / write-port decisions.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    drop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_run_i) begin
          restart = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (wr_run_i) begin
          // Restart: flush and reload, no pop or push this cycle.
          restart = 1'b1;
        end else begin
          pop = !empty && gnt_i;
          // Pixels past the frame size are discarded silently.
          if (pixel_en_i && frame_open) begin
            if (!full || pop) push = 1'b1;
            else              drop = 1'b1;
          end
          if (pop && at_last) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage (no reset needed: only read behind the occupancy count).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pixel_i;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (restart) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  // Write port, address/counters, overflow flag and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena_o     <= 1'b0;
      wea_o     <= 1'b0;
      addr_o    <= '0;
      d2mem_o   <= '0;
      wr_done_o <= 1'b0;
      ovf_o     <= 1'b0;
      cnt_row_o <= '0;
      cnt_col_o <= '0;
      addr_q    <= '0;
      push_cnt  <= '0;
    end else begin
      ena_o     <= pop;
      wea_o     <= pop;
      wr_done_o <= (state_q == S_DONE);
      if (pop) begin
        addr_o  <= addr_q;
        d2mem_o <= mem[rd_ptr];
      end
      if (restart) begin
        addr_q    <= AW'(BASE_ADDR);
        cnt_row_o <= '0;
        cnt_col_o <= '0;
        ovf_o     <= 1'b0;
        push_cnt  <= '0;
      end else begin
        if (pop) begin
          addr_q <= addr_q + AW'(1);
          if (col_end) begin
            cnt_col_o <= '0;
            cnt_row_o <= cnt_row_o + CW'(1);
          end else begin
            cnt_col_o <= cnt_col_o + CW'(1);
          end
        end
        if (push) push_cnt <= push_cnt + PCW'(1);
        if (drop) ovf_o <= 1'b1;
      end
    end
  end

endmodule
